// File: rtl/load_use_scoreboard_if.sv
// Hazard-unit bus: ID source operands, EX producer info and the stall controls returned to the pipeline.
// The master drives the pipeline-side signals and the slave is the hazard unit.
interface load_use_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs1_i;
  logic [REG_W-1:0] id_rs2_i;
  logic             id_rs1_use_i;
  logic             id_rs2_use_i;
  logic [REG_W-1:0] ex_rd_i;
  logic             ex_memread_i;
  logic             ex_valid_i;
  logic             mem_stall_i;
  logic             mux_o;
  logic             IFID_write_o;
  logic             pc_write_o;
  logic             busy_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
    output ex_rd_i, ex_memread_i, ex_valid_i, mem_stall_i,
    input  mux_o, IFID_write_o, pc_write_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
    input  ex_rd_i, ex_memread_i, ex_valid_i, mem_stall_i,
    output mux_o, IFID_write_o, pc_write_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit with a per-register countdown scoreboard covering a configurable load latency.
// Produces the bubble/hold controls combinationally and keeps a saturating count of stall cycles.
module load_use_scoreboard #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  load_use_scoreboard_if.slave bus
);

  localparam int NUM_REGS = 1 << REG_W;
  localparam int CW       = $clog2(LOAD_LAT + 1);

  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_LOAD  = CW'(LOAD_LAT - 1);
  localparam logic [REG_W-1:0] REG_ZERO  = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  logic [CW-1:0]    cnt_q [1:NUM_REGS-1];
  logic [CW-1:0]    cnt_d [1:NUM_REGS-1];
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  logic ex_load_s;
  logic ex_hit_s;
  logic sb_hit_s;
  logic busy_s;
  logic hazard_s;

  // Scoreboard lookup for both ID sources plus the busy summary.
  always_comb begin
    sb_hit_s = 1'b0;
    busy_s   = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (cnt_q[r] != CNT_ZERO) begin
        busy_s = 1'b1;
        if (bus.id_rs1_use_i && (bus.id_rs1_i == REG_W'(r))) begin
          sb_hit_s = 1'b1;
        end else if (bus.id_rs2_use_i && (bus.id_rs2_i == REG_W'(r))) begin
          sb_hit_s = 1'b1;
        end else begin
          sb_hit_s = sb_hit_s;
        end
      end else begin
        busy_s = busy_s;
      end
    end
  end

  // Direct EX-stage load match and the final hazard/freeze decision.
  always_comb begin
    ex_load_s = bus.ex_valid_i & bus.ex_memread_i & (bus.ex_rd_i != REG_ZERO);
    ex_hit_s  = ex_load_s &
                ((bus.id_rs1_use_i & (bus.id_rs1_i == bus.ex_rd_i)) |
                 (bus.id_rs2_use_i & (bus.id_rs2_i == bus.ex_rd_i)));
    hazard_s  = (ex_hit_s | sb_hit_s) & ~bus.mem_stall_i;
  end

  assign bus.mux_o        = hazard_s;
  assign bus.IFID_write_o = ~(hazard_s | bus.mem_stall_i);
  assign bus.pc_write_o   = ~(hazard_s | bus.mem_stall_i);
  assign bus.busy_o       = busy_s;
  assign bus.stall_cnt_o  = stall_q;

  // Countdown next state: a memory freeze holds everything, and a new load beats the decrement.
  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (bus.mem_stall_i) begin
        cnt_d[r] = cnt_q[r];
      end else if (ex_load_s && (bus.ex_rd_i == REG_W'(r))) begin
        cnt_d[r] = CNT_LOAD;
      end else if (cnt_q[r] != CNT_ZERO) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    stall_d = stall_q;
    if (hazard_s && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      stall_q <= {CNT_W{1'b0}};
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Scoreboard bench: three hazard units (latency 1/2/8) share one randomized stimulus stream and are
// checked against a ready-time reference model through an expectation queue.
module tb_load_use_scoreboard;

  localparam int NI = 3;

  typedef struct {
    int   inst;
    logic mux;
    logic wr;
    logic busy;
    int   stall;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, mr, ev, ms;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  int        lat  [NI] = '{1, 2, 8};
  int        smax [NI] = '{65535, 15, 15};
  longint    avail[NI][32];
  int        e_stall[NI];
  longint    nf;

  load_use_scoreboard_if #(.REG_W(5), .CNT_W(16)) if0 ();
  load_use_scoreboard_if #(.REG_W(5), .CNT_W(4))  if1 ();
  load_use_scoreboard_if #(.REG_W(5), .CNT_W(4))  if2 ();

  load_use_scoreboard #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) dut0 (.clk_i(clk), .rst_i(rst_n), .bus(if0.slave));
  load_use_scoreboard #(.REG_W(5), .LOAD_LAT(2), .CNT_W(4))  dut1 (.clk_i(clk), .rst_i(rst_n), .bus(if1.slave));
  load_use_scoreboard #(.REG_W(5), .LOAD_LAT(8), .CNT_W(4))  dut2 (.clk_i(clk), .rst_i(rst_n), .bus(if2.slave));

  assign if0.id_rs1_i = rs1; assign if0.id_rs2_i = rs2; assign if0.id_rs1_use_i = u1; assign if0.id_rs2_use_i = u2;
  assign if0.ex_rd_i = rd;   assign if0.ex_memread_i = mr; assign if0.ex_valid_i = ev; assign if0.mem_stall_i = ms;
  assign if1.id_rs1_i = rs1; assign if1.id_rs2_i = rs2; assign if1.id_rs1_use_i = u1; assign if1.id_rs2_use_i = u2;
  assign if1.ex_rd_i = rd;   assign if1.ex_memread_i = mr; assign if1.ex_valid_i = ev; assign if1.mem_stall_i = ms;
  assign if2.id_rs1_i = rs1; assign if2.id_rs2_i = rs2; assign if2.id_rs1_use_i = u1; assign if2.id_rs2_use_i = u2;
  assign if2.ex_rd_i = rd;   assign if2.ex_memread_i = mr; assign if2.ex_valid_i = ev; assign if2.mem_stall_i = ms;

  logic a_mux [NI];
  logic a_ifid[NI];
  logic a_pc  [NI];
  logic a_busy[NI];
  int   a_stall[NI];

  assign a_mux[0] = if0.mux_o;  assign a_ifid[0] = if0.IFID_write_o; assign a_pc[0] = if0.pc_write_o;
  assign a_mux[1] = if1.mux_o;  assign a_ifid[1] = if1.IFID_write_o; assign a_pc[1] = if1.pc_write_o;
  assign a_mux[2] = if2.mux_o;  assign a_ifid[2] = if2.IFID_write_o; assign a_pc[2] = if2.pc_write_o;
  assign a_busy[0] = if0.busy_o; assign a_busy[1] = if1.busy_o; assign a_busy[2] = if2.busy_o;
  assign a_stall[0] = int'(if0.stall_cnt_o);
  assign a_stall[1] = int'(if1.stall_cnt_o);
  assign a_stall[2] = int'(if2.stall_cnt_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s inst=%0d L=%0d time=%0t actual=%0d expected=%0d", name, inst, lat[inst], $time, act, expv);
    end
  endtask

  // Monitor: compares every queued expectation against the live DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mux_o",        e.inst, int'(a_mux[e.inst]),  int'(e.mux));
        chk("IFID_write_o", e.inst, int'(a_ifid[e.inst]), int'(e.wr));
        chk("pc_write_o",   e.inst, int'(a_pc[e.inst]),   int'(e.wr));
        chk("busy_o",       e.inst, int'(a_busy[e.inst]), int'(e.busy));
        chk("stall_cnt_o",  e.inst, a_stall[e.inst],      e.stall);
      end
    end
  end

  // One cycle: apply inputs at negedge, queue expectations, advance the model at the posedge.
  task automatic cycle(input logic [4:0] s1, input logic [4:0] s2, input logic su1, input logic su2,
                       input logic [4:0] d, input logic smr, input logic sev, input logic sms,
                       input logic srst_n);
    logic haz[NI];
    logic ex_load;
    logic ex_hit;
    logic sb;
    logic bsy;
    exp_t e;
    @(negedge clk);
    rs1 = s1; rs2 = s2; u1 = su1; u2 = su2; rd = d; mr = smr; ev = sev; ms = sms; rst_n = srst_n;
    if (!srst_n) begin
      for (int i = 0; i < NI; i++) begin
        e_stall[i] = 0;
        for (int r = 0; r < 32; r++) avail[i][r] = 0;
      end
    end
    ex_load = sev && smr && (d != 5'd0);
    ex_hit  = ex_load && ((su1 && s1 == d) || (su2 && s2 == d));
    for (int i = 0; i < NI; i++) begin
      // a register is still pending while fewer than L non-frozen edges have passed since its load
      sb  = (su1 && s1 != 5'd0 && avail[i][s1] > nf) || (su2 && s2 != 5'd0 && avail[i][s2] > nf);
      bsy = 1'b0;
      for (int r = 1; r < 32; r++) if (avail[i][r] > nf) bsy = 1'b1;
      haz[i] = (ex_hit || sb) && !sms;
      e.inst = i; e.mux = haz[i]; e.wr = !(haz[i] || sms); e.busy = bsy; e.stall = e_stall[i];
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (srst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (haz[i] && e_stall[i] < smax[i]) e_stall[i]++;
        if (ex_load && !sms) avail[i][d] = nf + lat[i];
      end
      if (!sms) nf++;
    end
  endtask

  initial begin
    checks = 0; failures = 0; nf = 0;
    rst_n = 1'b0; rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
    rd = 5'd0; mr = 1'b0; ev = 1'b0; ms = 1'b0;
    for (int i = 0; i < NI; i++) begin
      e_stall[i] = 0;
      for (int r = 0; r < 32; r++) avail[i][r] = 0;
    end
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    // load x5 with dependent rs1, then bubble in EX
    cycle(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) cycle(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    // load x7 with rs2 dependent, memory freeze mid-countdown
    cycle(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) cycle(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    // load to x0 and unused rs2 match must not stall
    cycle(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(5'd1, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    // back-to-back loads x3, x4, then readers, then reset mid-countdown
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(5'd4, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    // randomized traffic with occasional freezes and reset pulses
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] d, s1, s2;
      d  = 5'($urandom_range(0, 7));
      s1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 7));
      s2 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 7));
      cycle(s1, s2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
            ((n % 700) == 350 || (n % 700) == 351) ? 1'b0 : 1'b1);
    end
    repeat (2) @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
